// File: rtl/qenc_pkg.sv
// Shared definitions for the quadrature encoder generator.
// State codes, the direction type and the step function, used by the RTL and by the bench.
package qenc_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } qenc_dir_e;

  // {A,B} forward: 00->01->11->10->00. Reverse walks the same ring backwards.
  function automatic logic [1:0] qenc_next_state(input logic [1:0] s, input qenc_dir_e dir);
    logic [1:0] n;
    n = s;
    case (s)
      S00:     n = (dir == DIR_FWD) ? S01 : S10;
      S01:     n = (dir == DIR_FWD) ? S11 : S00;
      S11:     n = (dir == DIR_FWD) ? S10 : S01;
      default: n = (dir == DIR_FWD) ? S00 : S11;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qenc_phase_timer.sv
// Quarter-period counter: counts 0..period-1 while enabled, pulses wrap on the last count.
// Holds its count when enable is low; clear restarts the quarter from 0.
module qenc_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  assign wrap = enable && (period != '0) && (count_q == period - W'(1));

  always_comb begin
    count_d = count_q;
    if (clear || wrap) begin
      count_d = '0;
    end else if (enable && (period != '0)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: A/B/index at a programmed speed and direction.
// Optional QENC_GLITCH_EN adds glitch_req, which flips encoder_a for one clk per rising edge.
module quad_encoder_gen
  import qenc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CPR        = 64,
  parameter int POS_W      = $clog2(CPR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_quarter_period,
  input  logic                  cfg_dir,
`ifdef QENC_GLITCH_EN
  input  logic                  glitch_req,
`endif
  output logic                  encoder_a,
  output logic                  encoder_b,
  output logic                  index,
  output logic [POS_W-1:0]      position,
  output logic                  busy
);

  // state | meaning
  // S00   | A=0 B=0 (index phase when position==0)
  // S01   | A=0 B=1
  // S11   | A=1 B=1
  // S10   | A=1 B=0

  logic [DATA_WIDTH-1:0] act_qp_q, act_qp_d;
  qenc_dir_e             act_dir_q, act_dir_d;
  logic [DATA_WIDTH-1:0] pend_qp_q, pend_qp_d;
  qenc_dir_e             pend_dir_q, pend_dir_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  cfg_ready_q, cfg_ready_d;
  logic [1:0]            state_q, state_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  index_q, index_d;
  logic                  busy_q, busy_d;
  logic                  wrap, xfer, apply;

  assign xfer  = cfg_valid && cfg_ready_q;
  assign apply = pend_valid_q && ((act_qp_q == '0) || !enable || wrap);

  qenc_phase_timer #(.W(DATA_WIDTH)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (apply),
    .period (act_qp_q),
    .wrap   (wrap)
  );

  always_comb begin
    act_qp_d     = act_qp_q;
    act_dir_d    = act_dir_q;
    pend_qp_d    = pend_qp_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    cfg_ready_d  = cfg_ready_q;
    state_d      = state_q;
    pos_d        = pos_q;

    // cfg_ready re-opens one cycle after the pending slot empties.
    if (cfg_ready_q) cfg_ready_d = !xfer;
    else             cfg_ready_d = !pend_valid_q;

    if (apply) begin
      act_qp_d     = pend_qp_q;
      act_dir_d    = pend_dir_q;
      pend_valid_d = 1'b0;
    end
    if (xfer) begin
      pend_qp_d    = cfg_quarter_period;
      pend_dir_d   = qenc_dir_e'(cfg_dir);
      pend_valid_d = 1'b1;
    end

    // A boundary step always uses the direction that governed the finishing quarter.
    if (wrap) begin
      state_d = qenc_next_state(state_q, act_dir_q);
      pos_d   = (act_dir_q == DIR_FWD) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    end

    index_d = (state_d == S00) && (pos_d == '0);
    busy_d  = (act_qp_d != '0) && enable;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_qp_q     <= '0;
      act_dir_q    <= DIR_FWD;
      pend_qp_q    <= '0;
      pend_dir_q   <= DIR_FWD;
      pend_valid_q <= 1'b0;
      cfg_ready_q  <= 1'b1;
      state_q      <= S00;
      pos_q        <= '0;
      index_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      act_qp_q     <= act_qp_d;
      act_dir_q    <= act_dir_d;
      pend_qp_q    <= pend_qp_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      cfg_ready_q  <= cfg_ready_d;
      state_q      <= state_d;
      pos_q        <= pos_d;
      index_q      <= index_d;
      busy_q       <= busy_d;
    end
  end

`ifdef QENC_GLITCH_EN
  logic glitch_req_q;
  logic enc_a_q, enc_a_d;

  always_comb begin
    enc_a_d = state_d[1] ^ (glitch_req && !glitch_req_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_req_q <= 1'b0;
      enc_a_q      <= 1'b0;
    end else begin
      glitch_req_q <= glitch_req;
      enc_a_q      <= enc_a_d;
    end
  end

  assign encoder_a = enc_a_q;
`else
  assign encoder_a = state_q[1];
`endif

  assign encoder_b = state_q[0];
  assign index     = index_q;
  assign position  = pos_q;
  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen with hand-computed A/B/position/handshake expectations.
// Define QENC_GLITCH_EN on both RTL and bench to include the glitch checks.
module tb_quad_encoder_gen;
  import qenc_pkg::*;

  localparam int DW  = 16;
  localparam int CPR = 64;
  localparam int PW  = 6;

  logic          clk = 1'b0;
  logic          reset, enable, cfg_valid, cfg_dir;
  logic [DW-1:0] cfg_qp;
  logic          cfg_ready, encoder_a, encoder_b, index, busy;
  logic [PW-1:0] position;
`ifdef QENC_GLITCH_EN
  logic          glitch_req;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] fwd_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] rev_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  always #5 clk = ~clk;

  quad_encoder_gen #(.DATA_WIDTH(DW), .CPR(CPR), .POS_W(PW)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_quarter_period (cfg_qp),
    .cfg_dir            (cfg_dir),
`ifdef QENC_GLITCH_EN
    .glitch_req         (glitch_req),
`endif
    .encoder_a          (encoder_a),
    .encoder_b          (encoder_b),
    .index              (index),
    .position           (position),
    .busy               (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_ab(input string tag, input logic [1:0] exp_ab, input int exp_pos);
    check({tag, "_ab"}, 32'({encoder_a, encoder_b}), 32'(exp_ab));
    check({tag, "_pos"}, 32'(position), 32'(exp_pos));
    check({tag, "_idx"}, 32'(index), 32'((exp_ab == 2'b00) && (exp_pos == 0)));
  endtask

  // Returns at the negedge just after the transfer edge.
  task automatic send_cfg(input logic [DW-1:0] qp, input logic dir);
    int w;
    w = 0;
    while (!cfg_ready && w < 100) begin
      tick();
      w++;
    end
    if (!cfg_ready) check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_qp    = qp;
    cfg_dir   = dir;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    cfg_valid = 1'b0;
    cfg_qp    = '0;
    cfg_dir   = 1'b0;
`ifdef QENC_GLITCH_EN
    glitch_req = 1'b0;
`endif
    tick(2);
    check_ab("rst", 2'b00, 0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(3);
    check_ab("idle", 2'b00, 0);
    check("idle_busy", 32'(busy), 32'd0);

    // Forward, qp=4: step every 4 cycles starting 4 cycles after load.
    send_cfg(16'd4, 1'b0);
    check("fwd_ready_drop", 32'(cfg_ready), 32'd0);
    for (int t = 0; t <= 16; t++) begin
      tick();
      check_ab($sformatf("fwd_t%0d", t), fwd_seq[(t / 4) % 4], t / 4);
      if (t == 0) begin
        check("fwd_busy", 32'(busy), 32'd1);
        check("fwd_ready_t0", 32'(cfg_ready), 32'd0);
      end
      if (t == 1) check("fwd_ready_t1", 32'(cfg_ready), 32'd1);
    end

    // Pending config then async reset mid-quarter: everything clears, pending discarded.
    send_cfg(16'd1, 1'b0);
    check("rstmid_ready_pre", 32'(cfg_ready), 32'd0);
    check_ab("rstmid_pre", 2'b00, 4);
    reset = 1'b1;
    #1;
    check_ab("rstmid", 2'b00, 0);
    check("rstmid_ready", 32'(cfg_ready), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(6);
    check_ab("rstmid_after", 2'b00, 0);
    check("rstmid_after_busy", 32'(busy), 32'd0);

    // Reverse, qp=2, from position 0: 00 -> 10 at position 63.
    send_cfg(16'd2, 1'b1);
    for (int t = 0; t <= 8; t++) begin
      tick();
      check_ab($sformatf("rev_t%0d", t), rev_seq[(t / 2) % 4], (CPR - t / 2) % CPR);
    end

    // Mid-run change: qp=8 fwd, offer qp=3 rev at timer count 2.
    do_reset();
    send_cfg(16'd8, 1'b0);
    tick(3);
    send_cfg(16'd3, 1'b1);
    check("mid_ready_p4", 32'(cfg_ready), 32'd0);
    tick(4);
    check("mid_ready_p8", 32'(cfg_ready), 32'd0);
    check_ab("mid_p8", 2'b00, 0);
    tick();
    check_ab("mid_p9", 2'b01, 1);
    check("mid_ready_p9", 32'(cfg_ready), 32'd0);
    tick();
    check("mid_ready_p10", 32'(cfg_ready), 32'd1);
    tick(2);
    check_ab("mid_p12", 2'b00, 0);
    tick(2);
    check_ab("mid_p14", 2'b00, 0);
    tick();
    check_ab("mid_p15", 2'b10, 63);
    tick(3);
    check_ab("mid_p18", 2'b11, 62);

    // enable low at timer=5 for 10 cycles: count freezes and resumes at 5.
    do_reset();
    send_cfg(16'd8, 1'b0);
    tick(6);
    enable = 1'b0;
    tick(10);
    check_ab("en_hold", 2'b00, 0);
    check("en_hold_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick(2);
    check_ab("en_q18", 2'b00, 0);
    tick();
    check_ab("en_q19", 2'b01, 1);
    check("en_q19_busy", 32'(busy), 32'd1);

    // qp=0 applied at the next wrap, then frozen.
    send_cfg(16'd0, 1'b0);
    tick(6);
    check_ab("stop_q26", 2'b01, 1);
    check("stop_q26_busy", 32'(busy), 32'd1);
    tick();
    check_ab("stop_q27", 2'b11, 2);
    check("stop_q27_busy", 32'(busy), 32'd0);
    tick(20);
    check_ab("stop_hold", 2'b11, 2);
    check("stop_hold_busy", 32'(busy), 32'd0);
    check("stop_hold_ready", 32'(cfg_ready), 32'd1);

`ifdef QENC_GLITCH_EN
    glitch_req = 1'b1;
    tick();
    check("glitch_ab", 32'({encoder_a, encoder_b}), 32'h1);
    check("glitch_pos", 32'(position), 32'd2);
    tick();
    check("glitch_ab_after", 32'({encoder_a, encoder_b}), 32'h3);
    glitch_req = 1'b0;
    tick();
    check("glitch_ab_fall", 32'({encoder_a, encoder_b}), 32'h3);
`endif

    // qp=1 from stopped: first step 1 cycle after load, then every cycle.
    send_cfg(16'd1, 1'b0);
    tick();
    check_ab("qp1_r1", 2'b11, 2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_ab($sformatf("qp1_k%0d", k), fwd_seq[(2 + k) % 4], 2 + k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
